mem_bus_sched: RTL
==================

# mem_bus_sched

Phase sequencer and main-RAM arbiter for the C64 core. Generates the 1 MHz two-phase enables from the system clock and decides, once per 1 MHz cycle, whether the CPU, the VIC-II or a host DMA port (PRG loader / debugger) owns the main-RAM phase-1 slot. When DMA takes a slot it stalls the CPU through RDY. The block sits between the CPU, VIC-II and `spram2phase` main-RAM instance in the top level.

## Interface
Parameters:
- `DIV`, 8: system clocks per 1 MHz cycle; must be ≥ 4.
- `PH2_OFS`, 4: counter value at which `o_ph2_en` fires; range 1..DIV-1.

Ports:
- `clk` in 1: system clock; only clock.
- `rst` in 1: reset, synchronous and active-high.
- `o_ph1_en` out 1: phase-1 enable pulse.
- `o_ph2_en` out 1: phase-2 enable pulse.
- `i_vic_bm` in 1: 1 = CPU/DMA side may use slot; 0 = VIC owns slot.
- `i_vic_ba` in 1: 0 = VIC bad-line stall.
- `o_cpu_rdy` out 1: CPU RDY.
- `i_cpu_addr` in 16, `i_cpu_we` in 1, `i_cpu_do` in 8, `i_cpu_ram_cs` in 1: CPU bus and decoded RAM select.
- `i_vic_addr` in 16: VIC phase-1 address.
- `i_dma_req` in 1, `i_dma_we` in 1, `i_dma_addr` in 16, `i_dma_wdata` in 8: DMA request.
- `o_dma_ack` out 1: DMA completion pulse.
- `o_dma_rdata` out 8: DMA read data.
- `o_ram_addr` out 16, `o_ram_we` out 1, `o_ram_cs` out 1, `o_ram_di` out 8: to RAM phase-1 port.
- `i_ram_do` in 8: RAM phase-1 read data.
- `o_owner` out 2: current slot owner. 0 = CPU, 1 = VIC, 2 = DMA.

## Operation
Phase counter:
- `cnt` counts 0..DIV-1 and wraps.
- `o_ph1_en = (cnt==0)`, `o_ph2_en = (cnt==PH2_OFS)`.
- Both enables are forced to 0 while `rst` is high.

Owner decision:
- Registered on the edge that ends a `cnt==DIV-1` cycle, from `i_vic_bm` and `i_dma_req` sampled in that cycle.
- Priority: `i_vic_bm==0` → VIC. Otherwise, `i_dma_req & ~last_dma` → DMA. Otherwise CPU.
- `last_dma` is set when DMA is granted and cleared when the CPU is granted. Consequence: DMA gets at most every other CPU-eligible slot, so the CPU is never starved.
- A VIC slot leaves `last_dma` unchanged.

Mux, driven by `o_owner`:
- VIC: address = `i_vic_addr`, `cs=1`, `we=0`.
- CPU: address = `i_cpu_addr`, `cs = i_cpu_ram_cs`, `we = i_cpu_we & i_cpu_ram_cs`, `di = i_cpu_do`.
- DMA: address = `i_dma_addr`, `cs=1`, `we = i_dma_we`, `di = i_dma_wdata`.
- `o_ram_we` is additionally gated by `o_ph1_en`.

CPU ready:
- `o_cpu_rdy = o_ph1_en & i_vic_ba & (o_owner==CPU)`.

DMA finite-state machine (FSM):
- IDLE → GRANT: when the owner register loads DMA.
- GRANT: lasts the `cnt==0` cycle; the RAM access happens here.
- GRANT → ACK.
- ACK: the `cnt==1` cycle. `o_dma_ack=1` for exactly one cycle. `o_dma_rdata` captures `i_ram_do` and holds it until the next ACK (writes also capture).
- ACK → IDLE.

DMA handshake rules:
- Requester holds req/addr/we/wdata stable from assertion until ack.
- Requester may drop req, or present a new request, in the cycle after ack.
- A req dropped before it is sampled at `cnt==DIV-1` produces no access and no ack.

## Timing
Reset values:
- `cnt=0`, `o_owner=CPU`, `last_dma=0`, FSM=IDLE, `o_dma_ack=0`, `o_dma_rdata=0`.
- All enables and `o_ram_we` are 0.

After reset:
- First cycle with `rst` low has `cnt=0`, so `o_ph1_en=1` and the CPU slot is active.

DMA latency:
- Best case: req seen at `cnt==DIV-1` → ack 2 cycles later (`cnt==1`).
- Worst case: 2·DIV+1 cycles plus VIC-owned slots.

Boundary conditions:
- Simultaneous `i_vic_bm=0` and DMA req: VIC wins; req stays pending; `last_dma` is unchanged.
- `rst` asserted during GRANT or ACK: access is abandoned, no ack issued, FSM returns to IDLE.
- The write already issued in GRANT is not undone.

## Structure
- Shared package `c64_pkg` holds:
  - owner encoding constants `OWN_CPU=2'd0`, `OWN_VIC=2'd1`, `OWN_DMA=2'd2`;
  - DMA FSM state constants.
- One natural sub-module: `phase_gen`, containing the counter and the ph1/ph2 enables.
- Arbitration, mux and FSM live in `mem_bus_sched`.

## Test plan
1. Reset, then `rst` low with `DIV=8` → `o_ph1_en` at cycles 0, 8, 16; `o_ph2_en` at cycles 4, 12; `o_owner=0`.
2. DMA write of 0x5A to 0x0801 with `i_vic_bm=1` → `o_ram_addr=0x0801`, `o_ram_we=1` at the next `cnt==0`. In that slot `o_cpu_rdy=0`. `o_dma_ack` pulses at `cnt==1`.
3. DMA read of 0x0801 after step 2 → `o_dma_rdata=0x5A` at ack and held after ack drops.
4. `i_dma_req` held high continuously for 6 slots → owner sequence DMA, CPU, DMA, CPU, DMA, CPU.
5. `i_vic_bm=0` for 3 slots while DMA pending → owner VIC ×3, then DMA; `o_ram_addr` tracks `i_vic_addr` during VIC slots.
6. `rst` pulsed during a DMA GRANT cycle → no `o_dma_ack`; post-reset owner is CPU; `cnt` restarts at 0.

Source files
------------

// File: rtl/c64_pkg.sv
// Shared encodings for the C64 main-RAM scheduler: slot-owner codes and DMA FSM states.
package c64_pkg;

    localparam logic [1:0] OWN_CPU = 2'd0;
    localparam logic [1:0] OWN_VIC = 2'd1;
    localparam logic [1:0] OWN_DMA = 2'd2;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_GRANT = 2'd1,
        DMA_ACK   = 2'd2
    } dma_st_t;

endpackage

// File: rtl/phase_gen.sv
// 1 MHz two-phase enable generator: free-running 0..DIV-1 counter, ph1 at 0, ph2 at PH2_OFS.
// Enables are combinational from the counter and held low while reset is asserted.
module phase_gen #(
    parameter int DIV     = 8,
    parameter int PH2_OFS = 4,
    parameter int CW      = $clog2(DIV)
) (
    input  logic clk,
    input  logic rst,
    output logic ph1_en_o,
    output logic ph2_en_o,
    output logic slot_end_o
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PH2  = CW'(PH2_OFS);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ph1_en_o   = ~rst & (cnt_q == '0);
    assign ph2_en_o   = ~rst & (cnt_q == CNT_PH2);
    // Last cycle of the 1 MHz period: the owner for the next slot is decided here.
    assign slot_end_o = ~rst & (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_bus_sched.sv
// Main-RAM phase-1 slot arbiter (VIC > DMA > CPU, DMA alternating with CPU) plus RAM port mux.
// DMA access happens in the cnt==0 slot and is acknowledged in the following cycle.
module mem_bus_sched
    import c64_pkg::*;
#(
    parameter int DIV     = 8,
    parameter int PH2_OFS = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_ph1_en,
    output logic        o_ph2_en,
    input  logic        i_vic_bm,
    input  logic        i_vic_ba,
    output logic        o_cpu_rdy,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_we,
    input  logic [7:0]  i_cpu_do,
    input  logic        i_cpu_ram_cs,
    input  logic [15:0] i_vic_addr,
    input  logic        i_dma_req,
    input  logic        i_dma_we,
    input  logic [15:0] i_dma_addr,
    input  logic [7:0]  i_dma_wdata,
    output logic        o_dma_ack,
    output logic [7:0]  o_dma_rdata,
    output logic [15:0] o_ram_addr,
    output logic        o_ram_we,
    output logic        o_ram_cs,
    output logic [7:0]  o_ram_di,
    input  logic [7:0]  i_ram_do,
    output logic [1:0]  o_owner
);

    logic       slot_end;
    logic [1:0] owner_q, owner_d;
    logic       last_dma_q, last_dma_d;
    logic       grant_dma;
    dma_st_t    st_q;
    logic       ack_q;
    logic [7:0] rdata_q;
    logic       we_sel;

    phase_gen #(
        .DIV     (DIV),
        .PH2_OFS (PH2_OFS)
    ) u_phase_gen (
        .clk        (clk),
        .rst        (rst),
        .ph1_en_o   (o_ph1_en),
        .ph2_en_o   (o_ph2_en),
        .slot_end_o (slot_end)
    );

    assign grant_dma = i_vic_bm & i_dma_req & ~last_dma_q;

    // A VIC slot leaves last_dma alone so a pending DMA keeps its turn.
    always_comb begin
        owner_d    = owner_q;
        last_dma_d = last_dma_q;
        if (slot_end) begin
            if (!i_vic_bm) begin
                owner_d = OWN_VIC;
            end else if (grant_dma) begin
                owner_d    = OWN_DMA;
                last_dma_d = 1'b1;
            end else begin
                owner_d    = OWN_CPU;
                last_dma_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= OWN_CPU;
            last_dma_q <= 1'b0;
            st_q       <= DMA_IDLE;
            ack_q      <= 1'b0;
            rdata_q    <= 8'h00;
        end else begin
            owner_q    <= owner_d;
            last_dma_q <= last_dma_d;
            ack_q      <= 1'b0;
            case (st_q)
                DMA_IDLE: begin
                    if (slot_end && grant_dma) begin
                        st_q <= DMA_GRANT;
                    end
                end
                DMA_GRANT: begin
                    st_q    <= DMA_ACK;
                    ack_q   <= 1'b1;
                    rdata_q <= i_ram_do;
                end
                DMA_ACK: begin
                    st_q <= DMA_IDLE;
                end
                default: begin
                    st_q <= DMA_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_ram_addr = i_cpu_addr;
        o_ram_cs   = i_cpu_ram_cs;
        o_ram_di   = i_cpu_do;
        we_sel     = i_cpu_we & i_cpu_ram_cs;
        case (owner_q)
            OWN_VIC: begin
                o_ram_addr = i_vic_addr;
                o_ram_cs   = 1'b1;
                we_sel     = 1'b0;
            end
            OWN_DMA: begin
                o_ram_addr = i_dma_addr;
                o_ram_cs   = 1'b1;
                o_ram_di   = i_dma_wdata;
                we_sel     = i_dma_we;
            end
            default: begin
            end
        endcase
    end

    assign o_ram_we    = we_sel & o_ph1_en;
    assign o_cpu_rdy   = o_ph1_en & i_vic_ba & (owner_q == OWN_CPU);
    assign o_owner     = owner_q;
    assign o_dma_ack   = ack_q;
    assign o_dma_rdata = rdata_q;

endmodule
